// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the single-port SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic {
        StInit,
        StIdle
    } ctrl_state_e;

    function automatic int unsigned lane_width(input int unsigned data_w,
                                               input int unsigned mask_w);
        return data_w / mask_w;
    endfunction

endpackage

// File: rtl/sram_rw_grant.sv
// Write-priority grant between one writer and one reader, with a starvation counter that
// forces a read grant after STARVE_LIMIT consecutive losses.
module sram_rw_grant
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic arb_en,
    input  logic w_valid,
    input  logic r_valid,
    output logic grant_w,
    output logic grant_r
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        grant_r      = arb_en & r_valid & (~w_valid | (starve_cnt_q == Limit));
        grant_w      = arb_en & w_valid & ~grant_r;
        starve_cnt_d = starve_cnt_q;
        // Only a lost arbitration counts; no arbitration happens while arb_en is low.
        if (!r_valid || grant_r) begin
            starve_cnt_d = '0;
        end else if (arb_en && (starve_cnt_q != Limit)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Single-port RW SRAM controller: post-reset zero fill, write/read arbitration and a
// 1-cycle read response path that holds the last read value.
module sram_rw_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W        = 2,
    parameter int unsigned DATA_W        = 392,
    parameter int unsigned MASK_W        = 4,
    parameter int unsigned STARVE_LIMIT  = 3,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [MASK_W-1:0] w_mask,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    ctrl_state_e       state_q;
    logic [ADDR_W-1:0] init_cnt_q;
    logic              rd_pend_q;
    logic [DATA_W-1:0] hold_q;

    logic init_drive;
    logic arb_en;
    logic grant_w;
    logic grant_r;

    // Gated by reset_n so the macro port stays quiet while reset is held.
    assign init_drive = (state_q == StInit) && reset_n;
    assign arb_en     = (state_q == StIdle) && reset_n;

    sram_rw_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clock   (clock),
        .reset_n (reset_n),
        .arb_en  (arb_en),
        .w_valid (w_valid),
        .r_valid (r_valid),
        .grant_w (grant_w),
        .grant_r (grant_r)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT_ON_RESET ? StInit : StIdle;
            init_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            rd_pend_q <= grant_r;
            if (rd_pend_q) begin
                hold_q <= sram_rdata;
            end
            if (state_q == StInit) begin
                init_cnt_q <= init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_q <= StIdle;
                end
            end
        end
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (init_drive) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_cnt_q;
            sram_wmask = '1;
        end else if (grant_w) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wmask = w_mask;
            sram_wdata = w_data;
        end else if (grant_r) begin
            sram_en    = 1'b1;
            sram_addr  = r_addr;
        end
    end

    assign w_ready    = grant_w;
    assign r_ready    = grant_r;
    assign init_done  = (state_q == StIdle);
    assign resp_valid = rd_pend_q;
    assign resp_data  = rd_pend_q ? sram_rdata : hold_q;

endmodule
